// File: rtl/uart_pkg.sv
// Shared types for the oversampled UART receiver.
// Parity modes, receiver FSM states and the clocks-per-bit floor.
package uart_pkg;

  localparam int MIN_CLKS_PER_BIT = 4;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  function automatic parity_e decode_parity(input logic [1:0] m);
    unique case (m)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous RX line.
// Resets to 1 so an idle line never looks like a start bit.
module uart_rx_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ff <= '1;
    else       ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver with parity, framing/overrun flags and valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of data, parity and stop bits.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] data_bits,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CPB = (CLKS_PER_BIT < MIN_CLKS_PER_BIT) ?
                       MIN_CLKS_PER_BIT : CLKS_PER_BIT;
  localparam int CW  = $clog2(CPB);
  localparam int MID = CPB / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int SMP = MID + 1;
`else
  localparam int SMP = MID;
`endif

  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);
  localparam logic [CW-1:0] MID_C   = CW'(MID);
  localparam logic [CW-1:0] SMP_C   = CW'(SMP);
  localparam logic [3:0]    LAST_D  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_S  = 4'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  parity_e              mode_q;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 fe_acc;
  logic                 pe_q;
  logic                 rx_s;
  logic                 smp_bit;
  logic                 tick;
  logic                 start_smp;
  logic                 last_data;
  logic                 last_stop;
  logic                 complete;
  logic                 frame_bad;

  uart_rx_sync #(.DEPTH(2)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist <= 2'b11;
    else       hist <= {hist[0], rx_s};
  end

  // Decision at mid+1 uses the samples from mid-1, mid and mid+1.
  assign smp_bit = (hist[1] & hist[0]) |
                   (hist[1] & rx_s) |
                   (hist[0] & rx_s);
`else
  assign smp_bit = rx_s;
`endif

  assign tick      = (cnt == SMP_C);
  assign start_smp = (cnt == MID_C);
  assign last_data = (bit_idx == LAST_D);
  assign last_stop = (bit_idx == LAST_S);
  assign complete  = (state_q == ST_STOP) && tick && last_stop;
  assign frame_bad = fe_acc | ~smp_bit;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (start_smp) state_d = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (tick && last_data)
          state_d = (mode_q != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (complete) state_d = frame_bad ? ST_WAIT_IDLE : ST_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter runs free from start detect, so later samples land at bit centres.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      fe_acc  <= 1'b0;
      pe_q    <= 1'b0;
      mode_q  <= PAR_NONE;
    end else begin
      if (state_q == ST_IDLE || cnt == CNT_MAX) cnt <= '0;
      else                                      cnt <= cnt + CW'(1);
      unique case (state_q)
        ST_IDLE: begin
          bit_idx <= '0;
          fe_acc  <= 1'b0;
          pe_q    <= 1'b0;
          if (!rx_s) mode_q <= decode_parity(parity_mode);
        end
        ST_DATA: begin
          if (tick) begin
            shreg   <= {smp_bit, shreg[DATA_BITS-1:1]};
            bit_idx <= last_data ? 4'd0 : bit_idx + 4'd1;
          end
        end
        ST_PARITY: begin
          if (tick) pe_q <= ((^shreg) ^ smp_bit) != (mode_q == PAR_ODD);
        end
        ST_STOP: begin
          if (tick) begin
            bit_idx <= bit_idx + 4'd1;
            if (!smp_bit) fe_acc <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_bits  <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (complete) begin
      if (!rx_valid || rx_ready) begin
        data_bits  <= shreg;
        frame_err  <= frame_bad;
        parity_err <= pe_q;
        rx_valid   <= 1'b1;
        if (rx_valid) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: vector table, corner sequences, random frames.
// Expected words come from a frame-level model of data, parity and stop rules.
module tb_uart_rx_frame;

  localparam int CPB  = 8;
  localparam int GPOS = 5;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic       rx_ready;
  logic [1:0] parity_mode;
  logic [7:0] data_bits;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_frame #(
    .DATA_BITS    (8),
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (1)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx          (rx),
    .parity_mode (parity_mode),
    .data_bits   (data_bits),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } word_t;

  typedef struct {
    string      nm;
    logic [7:0] d;
    logic [1:0] mode;
    logic       pbit;
    logic       stop;
    logic [7:0] xd;
    logic       xfe;
    logic       xpe;
  } vec_t;

  word_t got_q[$];
  int    total = 0;
  int    bad = 0;
  int    valid_cycles = 0;
  bit    busy_seen = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (rx_valid) valid_cycles++;
      if (busy) busy_seen = 1;
      if (rx_valid && rx_ready)
        got_q.push_back({data_bits, frame_err, parity_err});
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic model_pe(input logic [7:0] d, input logic [1:0] mode,
                                    input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    if (mode == 2'b01) return (ones % 2) != 0;
    if (mode == 2'b10) return (ones % 2) == 0;
    return 1'b0;
  endfunction

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int idx, input int gbit);
    for (int c = 0; c < CPB; c++) begin
      rx = (idx == gbit && c == GPOS) ? ~b : b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] mode,
                            input logic pbit, input logic stop, input int gbit);
    parity_mode = mode;
    drive_bit(1'b0, -2, gbit);
    parity_mode = 2'($urandom);
    for (int i = 0; i < 8; i++) drive_bit(d[i], i, gbit);
    if (mode == 2'b01 || mode == 2'b10) drive_bit(pbit, -2, gbit);
    drive_bit(stop, -2, gbit);
  endtask

  task automatic wait_word(input string name, output word_t w);
    int n;
    n = 0;
    while (got_q.size() == 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_arrive"}, got_q.size() != 0, 1);
    if (got_q.size() != 0) w = got_q.pop_front();
    else                   w = '0;
  endtask

  task automatic run_frame(input string name, input logic [7:0] d,
                           input logic [1:0] mode, input logic pbit,
                           input logic stop, input int gbit, input int gap,
                           input logic [7:0] xd, input logic xfe,
                           input logic xpe);
    word_t w;
    send_frame(d, mode, pbit, stop, gbit);
    rx = 1'b1;
    tick_n(gap);
    wait_word(name, w);
    check({name, "_data"}, w.d, xd);
    check({name, "_fe"}, w.fe, xfe);
    check({name, "_pe"}, w.pe, xpe);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vt[10];
    word_t w;
    int    lows;
    logic [7:0] rd;
    logic [1:0] rm;
    logic       rp;
    logic       rs;

    vt[0] = '{"n1_55", 8'h55, 2'b00, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vt[1] = '{"n1_a3", 8'hA3, 2'b00, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
    vt[2] = '{"n1_00", 8'h00, 2'b00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[3] = '{"n1_ff", 8'hFF, 2'b00, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vt[4] = '{"ev_ok", 8'hA3, 2'b01, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
    vt[5] = '{"ev_bad", 8'hA3, 2'b01, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1};
    vt[6] = '{"od_ok", 8'h81, 2'b10, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    vt[7] = '{"od_bad", 8'hF0, 2'b10, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1};
    vt[8] = '{"mode11", 8'h5A, 2'b11, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vt[9] = '{"stop0", 8'h3C, 2'b00, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};

    rstn = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b1;
    parity_mode = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_data", data_bits, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_fe", frame_err, 0);
    check("rst_pe", parity_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick_n(4);

    for (int i = 0; i < 10; i++) begin
      valid_cycles = 0;
      run_frame(vt[i].nm, vt[i].d, vt[i].mode, vt[i].pbit, vt[i].stop, -1,
                $urandom_range(2, 20), vt[i].xd, vt[i].xfe, vt[i].xpe);
      check({vt[i].nm, "_pulse"}, valid_cycles, 1);
    end

    // Broken stop bit followed by a stuck-low line.
    send_frame(8'h3C, 2'b00, 1'b0, 1'b0, -1);
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (!busy) lows++;
    end
    check("hold_busy_lows", lows, 0);
    check("hold_one_word", got_q.size(), 1);
    wait_word("hold", w);
    check("hold_data", w.d, 8'h3C);
    check("hold_fe", w.fe, 1);
    @(posedge clk);
    #1;
    rx = 1'b1;
    tick_n(6);
    check("hold_idle", busy, 0);
    run_frame("after_hold", 8'h5A, 2'b00, 1'b0, 1'b1, -1, 3,
              8'h5A, 1'b0, 1'b0);

    // Overrun while the consumer stalls.
    rx_ready = 1'b0;
    send_frame(8'h7E, 2'b00, 1'b0, 1'b1, -1);
    rx = 1'b1;
    tick_n(5);
    send_frame(8'hC3, 2'b00, 1'b0, 1'b1, -1);
    rx = 1'b1;
    tick_n(5);
    @(negedge clk);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", data_bits, 8'h7E);
    check("ovr_flag", overrun, 1);
    check("ovr_none_taken", got_q.size(), 0);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_clr", rx_valid, 0);
    check("ovr_flag_clr", overrun, 0);
    wait_word("ovr", w);
    check("ovr_taken", w.d, 8'h7E);
    @(posedge clk);
    #1;
    rx_ready = 1'b1;

    // Short low glitch on an idle line.
    busy_seen = 0;
    valid_cycles = 0;
    rx = 1'b0;
    tick_n(2);
    rx = 1'b1;
    tick_n(12);
    check("glitch_seen", busy_seen, 1);
    check("glitch_busy", busy, 0);
    check("glitch_valid", valid_cycles, 0);
    check("glitch_words", got_q.size(), 0);

    // One-clock inverted pulse at the centre of data bit 3.
`ifdef UART_RX_MAJORITY_EN
    run_frame("maj", 8'h1E, 2'b00, 1'b0, 1'b1, 3, 4, 8'h1E, 1'b0, 1'b0);
`else
    run_frame("maj", 8'h1E, 2'b00, 1'b0, 1'b1, 3, 4, 8'h16, 1'b0, 1'b0);
`endif

    // Reset in the middle of a frame.
    parity_mode = 2'b00;
    rx = 1'b0;
    tick_n(30);
    rstn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", rx_valid, 0);
    rx = 1'b1;
    tick_n(3);
    rstn = 1'b1;
    tick_n(4);
    got_q.delete();
    run_frame("arst_next", 8'h96, 2'b01, 1'b0, 1'b1, -1, 3,
              8'h96, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom);
      rm = 2'($urandom_range(0, 3));
      rp = 1'($urandom);
      rs = ($urandom_range(0, 5) != 0);
      run_frame($sformatf("rnd%0d", i), rd, rm, rp, rs, -1,
                $urandom_range(2, 20), rd, ~rs, model_pe(rd, rm, rp));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
